// File: rtl/drive_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : drive_mux_pkg
// Purpose  : Shared constants, state encodings and width helpers for the
//            drive source mux and its frame counter. The default WIDTH/DEPTH
//            values are the same ones the pwm and silencer blocks use.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package drive_mux_pkg;

  // Defaults shared with the pwm / silencer datapath
  localparam int DEF_WIDTH   = 13;
  localparam int DEF_DEPTH   = 249;
  localparam int DEF_NUM_SRC = 4;
  localparam int DEF_IDX_W   = 16;
  localparam int STAT_W      = 16;

  // Source-mux state encoding; kept as plain 2-bit constants so older
  // tooling that consumes the state register keeps working.
  typedef logic [1:0] drive_state_t;
  localparam drive_state_t ST_RUN        = 2'd0;
  localparam drive_state_t ST_PENDING    = 2'd1;
  localparam drive_state_t ST_WAIT_START = 2'd2;
  localparam drive_state_t ST_HOLD       = 2'd3;

  // Select width for a given source count; never narrower than one bit.
  function automatic int sel_w(input int num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

  // Counter width needed to hold 0..depth-1; never narrower than one bit.
  function automatic int cnt_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage : drive_mux_pkg
`default_nettype wire

// File: rtl/drive_source_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : drive_source_mux_if
// Purpose  : Bundle of request/control, per-source sample streams and the
//            selected output stream of the drive source mux.
// Ports    : (signals)
//   sel_req / sel_req_valid        requested source + one-cycle strobe
//   start_idx_en / start_idx       start-index gating for the next switch
//   finish_idx_en / finish_idx     finish-index gating for current source
//   din_valid, duty_in, phase_in,
//   stm_idx_in                     per-source sample streams
//   duty, phase, dout_valid        selected (and possibly gated) stream
//   cur_sel, switch_pending,
//   sel_err                        status
//   switch_cnt, gated_frames       statistics, only with DRIVE_MUX_STATS_EN
// Modports : slave  - the mux side
//            master - the side that feeds sources and consumes the output
// Config   : DRIVE_MUX_STATS_EN adds the statistics counters
// Revision : 1.0 - initial release
// ============================================================================
interface drive_source_mux_if
  import drive_mux_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int IDX_W   = DEF_IDX_W,
  parameter int SEL_W   = sel_w(NUM_SRC)
)();

  logic [SEL_W-1:0]                  sel_req;
  logic                              sel_req_valid;
  logic                              start_idx_en;
  logic [IDX_W-1:0]                  start_idx;
  logic                              finish_idx_en;
  logic [IDX_W-1:0]                  finish_idx;
  logic [NUM_SRC-1:0]                din_valid;
  logic [NUM_SRC-1:0][WIDTH-1:0]     duty_in;
  logic [NUM_SRC-1:0][WIDTH-1:0]     phase_in;
  logic [NUM_SRC-1:0][IDX_W-1:0]     stm_idx_in;

  logic [WIDTH-1:0]                  duty;
  logic [WIDTH-1:0]                  phase;
  logic                              dout_valid;
  logic [SEL_W-1:0]                  cur_sel;
  logic                              switch_pending;
  logic                              sel_err;

`ifdef DRIVE_MUX_STATS_EN
  logic [STAT_W-1:0]                 switch_cnt;
  logic [STAT_W-1:0]                 gated_frames;

  modport slave (
    input  sel_req, sel_req_valid, start_idx_en, start_idx,
           finish_idx_en, finish_idx, din_valid, duty_in, phase_in, stm_idx_in,
    output duty, phase, dout_valid, cur_sel, switch_pending, sel_err,
           switch_cnt, gated_frames
  );

  modport master (
    output sel_req, sel_req_valid, start_idx_en, start_idx,
           finish_idx_en, finish_idx, din_valid, duty_in, phase_in, stm_idx_in,
    input  duty, phase, dout_valid, cur_sel, switch_pending, sel_err,
           switch_cnt, gated_frames
  );
`else
  modport slave (
    input  sel_req, sel_req_valid, start_idx_en, start_idx,
           finish_idx_en, finish_idx, din_valid, duty_in, phase_in, stm_idx_in,
    output duty, phase, dout_valid, cur_sel, switch_pending, sel_err
  );

  modport master (
    output sel_req, sel_req_valid, start_idx_en, start_idx,
           finish_idx_en, finish_idx, din_valid, duty_in, phase_in, stm_idx_in,
    input  duty, phase, dout_valid, cur_sel, switch_pending, sel_err
  );
`endif

endinterface : drive_source_mux_if
`default_nettype wire

// File: rtl/drive_frame_counter.sv
`default_nettype none
// ============================================================================
// Module   : drive_frame_counter
// Purpose  : Counts sample strobes 0..DEPTH-1 and wraps; flags the first and
//            last sample position of the frame in progress.
// Ports    :
//   clk     in   clock
//   rst_n   in   synchronous active-low reset
//   clr     in   synchronous clear back to sample 0
//   strobe  in   sample strobe of the source being counted
//   first   out  next counted sample is sample 0 of a frame
//   last    out  next counted sample is sample DEPTH-1 of a frame
// Revision : 1.0 - initial release
// ============================================================================
module drive_frame_counter
  import drive_mux_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic strobe,
  output logic first,
  output logic last
);

  localparam int               CNT_W  = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEPTH - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_count <= '0;
    end else if (strobe) begin
      r_count <= (r_count == C_LAST) ? '0 : r_count + CNT_W'(1);
    end
  end

  assign first = (r_count == '0);
  assign last  = (r_count == C_LAST);

endmodule : drive_frame_counter
`default_nettype wire

// File: rtl/drive_source_mux.sv
`default_nettype none
// ============================================================================
// Module   : drive_source_mux
// Purpose  : Selects one of NUM_SRC drive sources (normal, focus STM, gain
//            STM, ...) and forwards its duty/phase stream with one cycle of
//            latency. Source changes only take effect on a frame boundary of
//            the current source, so downstream never sees a mixed frame.
//            Optional start-index gating holds duty at 0 on the new source
//            until its STM index reaches START_IDX; finish-index gating
//            blanks duty after the frame whose index equals FINISH_IDX.
// Ports    :
//   clk     in   clock, all logic on rising edge
//   rst_n   in   synchronous active-low reset
//   bus     slave modport of drive_source_mux_if (requests, per-source
//           streams, selected output stream and status)
// Config   : DRIVE_MUX_STATS_EN adds saturating switch_cnt / gated_frames
// Revision : 1.0 - initial release
// ============================================================================
module drive_source_mux
  import drive_mux_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int IDX_W   = DEF_IDX_W,
  parameter int SEL_W   = sel_w(NUM_SRC)
) (
  input  logic              clk,
  input  logic              rst_n,
  drive_source_mux_if.slave bus
);

  localparam logic [SEL_W:0] C_NUM_SRC = (SEL_W + 1)'(NUM_SRC);

  drive_state_t     r_state;
  drive_state_t     w_state_nxt;
  logic [SEL_W-1:0] r_cur_sel;
  logic [SEL_W-1:0] r_tgt;
  logic [SEL_W-1:0] w_tgt_nxt;
  logic             r_pending;
  logic             w_pend_nxt;
  logic             r_req_sen;
  logic             w_sen_nxt;
  logic [IDX_W-1:0] r_req_sidx;
  logic [IDX_W-1:0] w_sidx_nxt;
  logic [IDX_W-1:0] r_act_sidx;
  logic [IDX_W-1:0] r_frame_idx;
  logic             r_gate;
  logic             r_sel_err;
  logic [WIDTH-1:0] r_duty;
  logic [WIDTH-1:0] r_phase;
  logic             r_dout_valid;

  logic             w_strobe;
  logic             w_first;
  logic             w_last;
  logic             w_boundary;
  logic             w_apply;
  logic             w_req_in_range;
  logic [IDX_W-1:0] w_cur_idx;
  logic             w_gate_new;
  logic             w_gate;

  // Only the selected source's strobe advances the frame.
  assign w_strobe   = bus.din_valid[r_cur_sel];
  assign w_boundary = w_strobe & w_last;

  drive_frame_counter #(
    .DEPTH (DEPTH)
  ) u_frame_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_apply),
    .strobe (w_strobe),
    .first  (w_first),
    .last   (w_last)
  );

  // The frame's STM index is whatever arrives with sample 0; later samples
  // of the frame use the held copy.
  assign w_cur_idx = w_first ? bus.stm_idx_in[r_cur_sel] : r_frame_idx;

  assign w_req_in_range = ({1'b0, bus.sel_req} < C_NUM_SRC);

  // Request bookkeeping as it will stand after this cycle. Folding the
  // current request in here lets a request on the boundary cycle itself
  // take effect at that boundary.
  always_comb begin
    w_pend_nxt = r_pending;
    w_tgt_nxt  = r_tgt;
    w_sen_nxt  = r_req_sen;
    w_sidx_nxt = r_req_sidx;
    if (bus.sel_req_valid && w_req_in_range) begin
      if (bus.sel_req == r_cur_sel) begin
        // Re-selecting the active source drops any pending switch.
        w_pend_nxt = 1'b0;
      end else begin
        w_pend_nxt = 1'b1;
        w_tgt_nxt  = bus.sel_req;
        w_sen_nxt  = bus.start_idx_en;
        w_sidx_nxt = bus.start_idx;
      end
    end
  end

  assign w_apply = w_boundary & w_pend_nxt;

  // Gating decision for a frame is made on its sample 0 and held.
  always_comb begin
    w_gate_new = 1'b0;
    case (r_state)
      ST_WAIT_START: w_gate_new = (w_cur_idx != r_act_sidx);
      ST_HOLD:       w_gate_new = 1'b1;
      default:       w_gate_new = 1'b0;
    endcase
  end

  assign w_gate = w_first ? w_gate_new : r_gate;

  always_comb begin
    w_state_nxt = r_state;
    if (w_apply) begin
      // A pending switch wins over finish gating on the same boundary.
      w_state_nxt = w_sen_nxt ? ST_WAIT_START : ST_RUN;
    end else begin
      case (r_state)
        ST_RUN, ST_PENDING: begin
          w_state_nxt = ST_RUN;
          if (w_boundary && bus.finish_idx_en && (w_cur_idx == bus.finish_idx)) begin
            w_state_nxt = ST_HOLD;
          end
        end
        ST_WAIT_START: begin
          if (w_strobe && w_first && !w_gate_new) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_HOLD: begin
          if (w_boundary && !bus.finish_idx_en) begin
            w_state_nxt = ST_RUN;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
      // PENDING marks a latched request while otherwise passing through;
      // in the gating states the request is tracked by r_pending alone.
      if (w_state_nxt == ST_RUN && w_pend_nxt) begin
        w_state_nxt = ST_PENDING;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_cur_sel    <= '0;
      r_tgt        <= '0;
      r_pending    <= 1'b0;
      r_req_sen    <= 1'b0;
      r_req_sidx   <= '0;
      r_act_sidx   <= '0;
      r_frame_idx  <= '0;
      r_gate       <= 1'b0;
      r_sel_err    <= 1'b0;
      r_duty       <= '0;
      r_phase      <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tgt      <= w_tgt_nxt;
      r_req_sen  <= w_sen_nxt;
      r_req_sidx <= w_sidx_nxt;
      r_sel_err  <= r_sel_err | (bus.sel_req_valid & ~w_req_in_range);

      if (w_apply) begin
        r_cur_sel  <= w_tgt_nxt;
        r_pending  <= 1'b0;
        r_act_sidx <= w_sidx_nxt;
      end else begin
        r_pending  <= w_pend_nxt;
      end

      r_dout_valid <= w_strobe;
      if (w_strobe) begin
        r_duty  <= w_gate ? '0 : bus.duty_in[r_cur_sel];
        r_phase <= bus.phase_in[r_cur_sel];
      end
      if (w_strobe && w_first) begin
        r_frame_idx <= bus.stm_idx_in[r_cur_sel];
        r_gate      <= w_gate_new;
      end
    end
  end

  assign bus.duty           = r_duty;
  assign bus.phase          = r_phase;
  assign bus.dout_valid     = r_dout_valid;
  assign bus.cur_sel        = r_cur_sel;
  assign bus.switch_pending = r_pending;
  assign bus.sel_err        = r_sel_err;

`ifdef DRIVE_MUX_STATS_EN
  logic [STAT_W-1:0] r_switch_cnt;
  logic [STAT_W-1:0] r_gated_frames;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_switch_cnt   <= '0;
      r_gated_frames <= '0;
    end else begin
      if (w_apply && (r_switch_cnt != '1)) begin
        r_switch_cnt <= r_switch_cnt + STAT_W'(1);
      end
      if (w_strobe && w_first && w_gate_new && (r_gated_frames != '1)) begin
        r_gated_frames <= r_gated_frames + STAT_W'(1);
      end
    end
  end

  assign bus.switch_cnt   = r_switch_cnt;
  assign bus.gated_frames = r_gated_frames;
`endif

endmodule : drive_source_mux
`default_nettype wire

// File: tb/tb_drive_source_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_drive_source_mux
// Purpose  : Self-checking bench for drive_source_mux. Three sources stream
//            continuously (duty 100/200/300, phase 1000/2000/3000); sources
//            1 and 2 report a shared STM index that steps once per frame,
//            source 0 reports index 0. SEL_REQ value 3 is out of range.
// Config   : DRIVE_MUX_STATS_EN also checks the statistics counters
// Revision : 1.0 - initial release
// ============================================================================
module tb_drive_source_mux;

  localparam int WIDTH   = 13;
  localparam int DEPTH   = 249;
  localparam int NUM_SRC = 3;
  localparam int IDX_W   = 16;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  drive_source_mux_if #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) bus ();

  drive_source_mux #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int g_cnt = 0;      // position of the next sample within the frame
  int g_idx = 0;      // STM index reported by sources 1 and 2
  int last_pend = 0;  // cycles switch_pending was seen high in last frame

  typedef struct {
    bit         req_v;
    logic [1:0] sel;
    bit         exp_pend;
    bit         exp_err;
  } req_vec_t;

  req_vec_t tbl [7];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: present the next sample, clock it, then look #1 later.
  // A gap withholds source 0's strobe while the others keep strobing.
  task automatic cyc(input bit gap);
    bus.din_valid = '1;
    if (gap) bus.din_valid[0] = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (s == 0) bus.stm_idx_in[s] = '0;
      else        bus.stm_idx_in[s] = IDX_W'(g_idx);
    end
    @(posedge clk);
    #1;
    bus.sel_req_valid = 1'b0;
    bus.start_idx_en  = 1'b0;
    if (!rst_n) begin
      g_cnt = 0;
      g_idx = 0;
    end else if (!gap) begin
      g_cnt++;
      if (g_cnt == DEPTH) begin
        g_cnt = 0;
        g_idx++;
      end
    end
  endtask

  // Runs until the end of the current frame, checking every output sample.
  task automatic run_frame(input string nm, input int exp_duty, input int exp_phase,
                           input int req_at, input int req_sel, input bit sen,
                           input int sidx, input int gap_at);
    int  nbad;
    int  pend;
    bit  done;
    nbad = 0;
    pend = 0;
    done = 1'b0;
    for (int k = 0; k < DEPTH + 8 && !done; k++) begin
      if (g_cnt == gap_at) begin
        for (int j = 0; j < 3; j++) begin
          cyc(1'b1);
          if (bus.dout_valid !== 1'b0) nbad++;
        end
      end
      if (g_cnt == req_at) begin
        bus.sel_req_valid = 1'b1;
        bus.sel_req       = 2'(req_sel);
        bus.start_idx_en  = sen;
        bus.start_idx     = IDX_W'(sidx);
      end
      cyc(1'b0);
      if (bus.dout_valid !== 1'b1 || bus.duty !== WIDTH'(exp_duty) ||
          bus.phase !== WIDTH'(exp_phase)) nbad++;
      if (bus.switch_pending === 1'b1) pend++;
      if (g_cnt == 0) done = 1'b1;
    end
    chk(nm, nbad, 0);
    last_pend = pend;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " duty"},  bus.duty, 0);
    chk({nm, " phase"}, bus.phase, 0);
    chk({nm, " valid"}, bus.dout_valid, 0);
    chk({nm, " cur"},   bus.cur_sel, 0);
    chk({nm, " pend"},  bus.switch_pending, 0);
    chk({nm, " err"},   bus.sel_err, 0);
  endtask

  initial begin
    // request-classification vectors, applied mid-frame on source 0
    tbl[0] = '{1'b1, 2'd0, 1'b0, 1'b0};  // same as current: ignored
    tbl[1] = '{1'b1, 2'd2, 1'b1, 1'b0};  // latch 2
    tbl[2] = '{1'b1, 2'd0, 1'b0, 1'b0};  // back to current: cancel
    tbl[3] = '{1'b1, 2'd3, 1'b0, 1'b1};  // out of range: ignored, error
    tbl[4] = '{1'b1, 2'd1, 1'b1, 1'b1};  // latch 1
    tbl[5] = '{1'b1, 2'd2, 1'b1, 1'b1};  // overwrite with 2
    tbl[6] = '{1'b0, 2'd0, 1'b1, 1'b1};  // idle: still pending, error sticky

    rst_n             = 1'b0;
    bus.sel_req       = '0;
    bus.sel_req_valid = 1'b0;
    bus.start_idx_en  = 1'b0;
    bus.start_idx     = '0;
    bus.finish_idx_en = 1'b0;
    bus.finish_idx    = '0;
    bus.din_valid     = '1;
    for (int s = 0; s < NUM_SRC; s++) begin
      bus.duty_in[s]    = WIDTH'((s + 1) * 100);
      bus.phase_in[s]   = WIDTH'((s + 1) * 1000);
      bus.stm_idx_in[s] = '0;
    end

    // reset held with sources streaming
    for (int i = 0; i < 3; i++) cyc(1'b0);
    chk_reset("reset");
    rst_n = 1'b1;

    // source 0 frame with a strobe gap while other sources keep strobing
    run_frame("gap frame", 100, 1000, -1, 0, 1'b0, 0, 40);
    chk("gap cur", bus.cur_sel, 0);

    // request at sample 10 applies at the end of this frame
    run_frame("switch frame", 100, 1000, 10, 1, 1'b0, 0, -1);
    chk("switch pend len", last_pend, 238);
    chk("switch cur", bus.cur_sel, 1);
    run_frame("src1 frame", 200, 2000, -1, 0, 1'b0, 0, -1);
    chk("src1 pend len", last_pend, 0);

    // request on the boundary sample itself
    run_frame("edge req frame", 200, 2000, 248, 0, 1'b0, 0, -1);
    chk("edge pend len", last_pend, 0);
    chk("edge cur", bus.cur_sel, 0);

    // table of mid-frame requests
    for (int i = 0; i < 7; i++) begin
      bus.sel_req_valid = tbl[i].req_v;
      bus.sel_req       = tbl[i].sel;
      cyc(1'b0);
      chk($sformatf("vec%0d pend", i), bus.switch_pending, tbl[i].exp_pend);
      chk($sformatf("vec%0d err", i), bus.sel_err, tbl[i].exp_err);
      chk($sformatf("vec%0d duty", i), bus.duty, 100);
    end
    run_frame("vec rest", 100, 1000, -1, 0, 1'b0, 0, -1);
    chk("vec rest pend len", last_pend, 241);
    chk("overwrite cur", bus.cur_sel, 2);

    // start gating: src1, START_IDX=5, src1 frames carry 3,4,5,6
    g_idx = 2;
    run_frame("start req frame", 300, 3000, 0, 1, 1'b1, 5, -1);
    chk("start pend len", last_pend, 248);
    chk("start cur", bus.cur_sel, 1);
    run_frame("start idx3", 0, 2000, -1, 0, 1'b0, 0, -1);
    run_frame("start idx4", 0, 2000, -1, 0, 1'b0, 0, -1);
    run_frame("start idx5", 200, 2000, -1, 0, 1'b0, 0, -1);
    run_frame("start idx6", 200, 2000, -1, 0, 1'b0, 0, -1);

    // finish gating at index 7, released by switching to source 0
    bus.finish_idx_en = 1'b1;
    bus.finish_idx    = IDX_W'(7);
    run_frame("finish idx7", 200, 2000, -1, 0, 1'b0, 0, -1);
    run_frame("finish idx8", 0, 2000, -1, 0, 1'b0, 0, -1);
    run_frame("finish idx9", 0, 2000, 100, 0, 1'b0, 0, -1);
    chk("finish pend len", last_pend, 148);
    chk("finish cur", bus.cur_sel, 0);

    // finish gating at index 11, released by dropping FINISH_IDX_EN
    bus.finish_idx = IDX_W'(11);
    run_frame("hold2 req frame", 100, 1000, 0, 1, 1'b0, 0, -1);
    chk("hold2 cur", bus.cur_sel, 1);
    run_frame("hold2 idx11", 200, 2000, -1, 0, 1'b0, 0, -1);
    bus.finish_idx_en = 1'b0;
    run_frame("hold2 idx12", 0, 2000, -1, 0, 1'b0, 0, -1);
    run_frame("hold2 idx13", 200, 2000, -1, 0, 1'b0, 0, -1);
    chk("err sticky", bus.sel_err, 1);

`ifdef DRIVE_MUX_STATS_EN
    chk("stats switches", bus.switch_cnt, 6);
    chk("stats gated", bus.gated_frames, 5);
`endif

    // reset mid-frame drops the partial frame
    for (int i = 0; i < 50; i++) cyc(1'b0);
    rst_n = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    chk_reset("midreset");
    rst_n = 1'b1;
    run_frame("post reset frame", 100, 1000, 0, 2, 1'b0, 0, -1);
    chk("post reset pend len", last_pend, 248);
    chk("post reset cur", bus.cur_sel, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_drive_source_mux
`default_nettype wire
